// File: rtl/control_sequencer_pkg.sv
// Shared encodings, control-word layout and lookup helpers for the hardwired
// control sequencer that drives the ALUSystem control bundle.
package cu_pkg;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } seq_state_e;

    localparam logic [3:0] OP_AND  = 4'h0;
    localparam logic [3:0] OP_OR   = 4'h1;
    localparam logic [3:0] OP_NOT  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_LDI  = 4'h5;
    localparam logic [3:0] OP_BRA  = 4'h6;
    localparam logic [3:0] OP_BNE  = 4'h7;
    localparam logic [3:0] OP_INC  = 4'h8;
    localparam logic [3:0] OP_DEC  = 4'h9;
    localparam logic [3:0] OP_MOV  = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] FUN_DEC   = 2'b00;
    localparam logic [1:0] FUN_INC   = 2'b01;
    localparam logic [1:0] FUN_LOAD  = 2'b10;
    localparam logic [1:0] FUN_CLEAR = 2'b11;

    localparam logic [1:0] IR_LOAD = 2'b10;

    localparam logic [3:0] ALU_PASS_A = 4'b0000;
    localparam logic [3:0] ALU_NOT_A  = 4'b0010;
    localparam logic [3:0] ALU_ADD    = 4'b0100;
    localparam logic [3:0] ALU_SUB    = 4'b0110;
    localparam logic [3:0] ALU_AND    = 4'b0111;
    localparam logic [3:0] ALU_OR     = 4'b1000;

    localparam logic [1:0] MUX_ALU  = 2'b00;
    localparam logic [1:0] MUX_MEM  = 2'b01;
    localparam logic [1:0] MUX_IMM  = 2'b10;
    localparam logic [1:0] MUX_ARFC = 2'b11;

    localparam logic [1:0] MUXC_RFA  = 2'b00;
    localparam logic [1:0] MUXC_ARFC = 2'b01;

    localparam logic [1:0] OUTD_PC = 2'b00;
    localparam logic [2:0] ARF_SEL_PC = 3'b011;

    typedef struct packed {
        logic [1:0] rfOutASel;
        logic [1:0] rfOutBSel;
        logic [1:0] rfFunSel;
        logic [3:0] rfRegSel;
        logic [3:0] aluFunSel;
        logic [1:0] arfOutCSel;
        logic [1:0] arfOutDSel;
        logic [1:0] arfFunSel;
        logic [2:0] arfRegSel;
        logic       irLH;
        logic       irEnable;
        logic [1:0] irFunsel;
        logic       memWR;
        logic       memCS;
        logic [1:0] muxASel;
        logic [1:0] muxBSel;
        logic [1:0] muxCSel;
    } ctrl_word_t;

    localparam ctrl_word_t IDLE_WORD = '{
        rfOutASel:  2'b00, rfOutBSel:  2'b00, rfFunSel:  2'b00, rfRegSel: 4'b1111,
        aluFunSel:  4'b0000,
        arfOutCSel: 2'b00, arfOutDSel: 2'b00, arfFunSel: 2'b00, arfRegSel: 3'b111,
        irLH: 1'b0, irEnable: 1'b0, irFunsel: 2'b00,
        memWR: 1'b0, memCS: 1'b1,
        muxASel: 2'b00, muxBSel: 2'b00, muxCSel: 2'b00
    };

    // Register index 0 is R1, which sits on the MSB of the active-low enable.
    function automatic logic [3:0] regSelLow(input logic [1:0] idx);
        case (idx)
            2'd0:    regSelLow = 4'b0111;
            2'd1:    regSelLow = 4'b1011;
            2'd2:    regSelLow = 4'b1101;
            2'd3:    regSelLow = 4'b1110;
            default: regSelLow = 4'b1111;
        endcase
    endfunction

    function automatic logic [3:0] aluOpFor(input logic [3:0] opcode);
        case (opcode)
            OP_AND:  aluOpFor = ALU_AND;
            OP_OR:   aluOpFor = ALU_OR;
            OP_ADD:  aluOpFor = ALU_ADD;
            OP_SUB:  aluOpFor = ALU_SUB;
            OP_NOT:  aluOpFor = ALU_NOT_A;
            default: aluOpFor = ALU_PASS_A;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// ALUSystem control bundle: the sequencer drives the controls and reads back
// the instruction register and ALU flags.
interface control_sequencer_if;
    logic [15:0] IROut;
    logic [3:0]  ALUOutFlag;
    logic [1:0]  RF_OutASel;
    logic [1:0]  RF_OutBSel;
    logic [1:0]  RF_FunSel;
    logic [3:0]  RF_RegSel;
    logic [3:0]  ALU_FunSel;
    logic [1:0]  ARF_OutCSel;
    logic [1:0]  ARF_OutDSel;
    logic [1:0]  ARF_FunSel;
    logic [2:0]  ARF_RegSel;
    logic        IR_LH;
    logic        IR_Enable;
    logic [1:0]  IR_Funsel;
    logic        Mem_WR;
    logic        Mem_CS;
    logic [1:0]  MuxASel;
    logic [1:0]  MuxBSel;
    logic [1:0]  MuxCSel;

    modport master (
        input  IROut, ALUOutFlag,
        output RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, ALU_FunSel,
               ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
               IR_LH, IR_Enable, IR_Funsel, Mem_WR, Mem_CS,
               MuxASel, MuxBSel, MuxCSel
    );

    modport slave (
        output IROut, ALUOutFlag,
        input  RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, ALU_FunSel,
               ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
               IR_LH, IR_Enable, IR_Funsel, Mem_WR, Mem_CS,
               MuxASel, MuxBSel, MuxCSel
    );
endinterface

// File: rtl/control_sequencer_sequence_counter.sv
// Two-bit T-state counter: advances each cycle, returns to T0 on nextT0 and
// freezes on hold.
module sequence_counter
    import cu_pkg::*;
(
    input  logic       Clock,
    input  logic       Reset,
    input  logic       nextT0,
    input  logic       hold,
    output seq_state_e sc
);

    seq_state_e sc_r;

    // T-state register with synchronous reset to T0.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            sc_r <= T0;
        end else if (hold) begin
            sc_r <= sc_r;
        end else if (nextT0) begin
            sc_r <= T0;
        end else begin
            sc_r <= seq_state_e'(sc_r + 2'd1);
        end
    end

    assign sc = sc_r;

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer producing the ALUSystem control
// word each cycle from the T-state, IROut and the Z flag.
module control_sequencer
    import cu_pkg::*;
#(
    parameter bit RESET_CLEARS_RF = 1'b1
) (
    input  logic                 Clock,
    input  logic                 Reset,
    control_sequencer_if.master  bus,
    output logic [1:0]           SC,
    output logic                 Halted
);

    seq_state_e scState_s;
    ctrl_word_t ctrlWord_s;
    logic       nextT0_s;
    logic       hold_s;
    logic       haltNow_s;
    logic       halted_r;
    logic [3:0] opcode_s;
    logic [1:0] rd_s;
    logic [1:0] rs1_s;
    logic [1:0] rs2_s;

    assign opcode_s = bus.IROut[15:12];
    assign rd_s     = bus.IROut[11:10];
    assign rs1_s    = bus.IROut[9:8];
    assign rs2_s    = bus.IROut[7:6];

    sequence_counter u_seqCounter (
        .Clock  (Clock),
        .Reset  (Reset),
        .nextT0 (nextT0_s),
        .hold   (hold_s),
        .sc     (scState_s)
    );

    // Halt latch; only Reset leaves the halted state.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            halted_r <= 1'b0;
        end else if (haltNow_s) begin
            halted_r <= 1'b1;
        end else begin
            halted_r <= halted_r;
        end
    end

    // Control word decode and next-T-state selection.
    always_comb begin
        ctrlWord_s = IDLE_WORD;
        nextT0_s   = 1'b0;
        hold_s     = 1'b0;
        haltNow_s  = 1'b0;
        if (Reset) begin
            ctrlWord_s.arfFunSel = FUN_CLEAR;
            ctrlWord_s.arfRegSel = 3'b000;
            ctrlWord_s.rfFunSel  = FUN_CLEAR;
            ctrlWord_s.rfRegSel  = RESET_CLEARS_RF ? 4'b0000 : 4'b1111;
        end else if (halted_r) begin
            hold_s = 1'b1;
        end else begin
            case (scState_s)
                T0, T1: begin
                    ctrlWord_s.memCS      = 1'b0;
                    ctrlWord_s.memWR      = 1'b0;
                    ctrlWord_s.arfOutDSel = OUTD_PC;
                    ctrlWord_s.irEnable   = 1'b1;
                    ctrlWord_s.irLH       = (scState_s == T1);
                    ctrlWord_s.irFunsel   = IR_LOAD;
                    ctrlWord_s.arfFunSel  = FUN_INC;
                    ctrlWord_s.arfRegSel  = ARF_SEL_PC;
                end
                T2: begin
                    nextT0_s = 1'b1;
                    case (opcode_s)
                        OP_AND, OP_OR, OP_ADD, OP_SUB, OP_NOT, OP_MOV, OP_INC, OP_DEC: begin
                            ctrlWord_s.rfOutASel = rs1_s;
                            ctrlWord_s.rfOutBSel = rs2_s;
                            ctrlWord_s.muxCSel   = MUXC_RFA;
                            ctrlWord_s.aluFunSel = aluOpFor(opcode_s);
                            ctrlWord_s.muxASel   = MUX_ALU;
                            ctrlWord_s.rfFunSel  = FUN_LOAD;
                            ctrlWord_s.rfRegSel  = regSelLow(rd_s);
                            // INC/DEC finish the +/-1 on Rd in T3.
                            nextT0_s = !((opcode_s == OP_INC) || (opcode_s == OP_DEC));
                        end
                        OP_LDI: begin
                            ctrlWord_s.muxASel  = MUX_IMM;
                            ctrlWord_s.rfFunSel = FUN_LOAD;
                            ctrlWord_s.rfRegSel = regSelLow(rd_s);
                        end
                        OP_BRA, OP_BNE: begin
                            if ((opcode_s == OP_BRA) || !bus.ALUOutFlag[3]) begin
                                ctrlWord_s.muxBSel   = MUX_IMM;
                                ctrlWord_s.arfFunSel = FUN_LOAD;
                                ctrlWord_s.arfRegSel = ARF_SEL_PC;
                            end else begin
                                ctrlWord_s = IDLE_WORD;
                            end
                        end
                        OP_HALT: begin
                            nextT0_s  = 1'b0;
                            hold_s    = 1'b1;
                            haltNow_s = 1'b1;
                        end
                        default: ctrlWord_s = IDLE_WORD;
                    endcase
                end
                T3: begin
                    ctrlWord_s.rfFunSel = (opcode_s == OP_DEC) ? FUN_DEC : FUN_INC;
                    ctrlWord_s.rfRegSel = regSelLow(rd_s);
                    nextT0_s            = 1'b1;
                end
                default: ctrlWord_s = IDLE_WORD;
            endcase
        end
    end

    assign bus.RF_OutASel  = ctrlWord_s.rfOutASel;
    assign bus.RF_OutBSel  = ctrlWord_s.rfOutBSel;
    assign bus.RF_FunSel   = ctrlWord_s.rfFunSel;
    assign bus.RF_RegSel   = ctrlWord_s.rfRegSel;
    assign bus.ALU_FunSel  = ctrlWord_s.aluFunSel;
    assign bus.ARF_OutCSel = ctrlWord_s.arfOutCSel;
    assign bus.ARF_OutDSel = ctrlWord_s.arfOutDSel;
    assign bus.ARF_FunSel  = ctrlWord_s.arfFunSel;
    assign bus.ARF_RegSel  = ctrlWord_s.arfRegSel;
    assign bus.IR_LH       = ctrlWord_s.irLH;
    assign bus.IR_Enable   = ctrlWord_s.irEnable;
    assign bus.IR_Funsel   = ctrlWord_s.irFunsel;
    assign bus.Mem_WR      = ctrlWord_s.memWR;
    assign bus.Mem_CS      = ctrlWord_s.memCS;
    assign bus.MuxASel     = ctrlWord_s.muxASel;
    assign bus.MuxBSel     = ctrlWord_s.muxBSel;
    assign bus.MuxCSel     = ctrlWord_s.muxCSel;

    assign SC     = scState_s;
    assign Halted = halted_r;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: a small memory/IR/PC model feeds IROut, stimulus queues
// per-cycle expected control fields, a monitor compares them mid-cycle.
module tb_control_sequencer;

    localparam int F_SC = 0, F_HALT = 1, F_IRLH = 2, F_IREN = 3, F_MEMCS = 4,
                   F_ARFREG = 5, F_ARFFUN = 6, F_RFREG = 7, F_RFFUN = 8,
                   F_ALU = 9, F_OUTA = 10, F_OUTB = 11, F_MUXA = 12, F_MUXB = 13;

    typedef struct {
        int          cyc;
        int          field;
        logic [15:0] val;
        string       name;
    } exp_t;

    logic        Clock;
    logic        Reset;
    logic [1:0]  sc;
    logic        halted;
    logic [3:0]  flag;
    logic [15:0] irModel;
    logic [7:0]  pcModel;
    logic [7:0]  mem [0:255];
    int          cyc;
    int          checks;
    int          passed;
    exp_t        scoreQ[$];

    control_sequencer_if bus();

    assign bus.IROut      = irModel;
    assign bus.ALUOutFlag = flag;

    control_sequencer #(.RESET_CLEARS_RF(1'b1)) dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .bus    (bus),
        .SC     (sc),
        .Halted (halted)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge Clock);
            cyc++;
        end
    end

    // Environment: byte memory, IR and PC react to the control outputs.
    always @(posedge Clock) begin
        if (bus.IR_Enable && (bus.IR_Funsel == 2'b10) && !bus.Mem_CS) begin
            if (bus.IR_LH) irModel[15:8] <= mem[pcModel];
            else           irModel[7:0]  <= mem[pcModel];
        end
        if (!bus.ARF_RegSel[2]) begin
            case (bus.ARF_FunSel)
                2'b00:   pcModel <= pcModel - 8'd1;
                2'b01:   pcModel <= pcModel + 8'd1;
                2'b10:   pcModel <= (bus.MuxBSel == 2'b10) ? irModel[7:0] : 8'd0;
                default: pcModel <= 8'd0;
            endcase
        end
    end

    function automatic logic [15:0] fieldVal(input int f);
        case (f)
            F_SC:     fieldVal = {14'd0, sc};
            F_HALT:   fieldVal = {15'd0, halted};
            F_IRLH:   fieldVal = {15'd0, bus.IR_LH};
            F_IREN:   fieldVal = {15'd0, bus.IR_Enable};
            F_MEMCS:  fieldVal = {15'd0, bus.Mem_CS};
            F_ARFREG: fieldVal = {13'd0, bus.ARF_RegSel};
            F_ARFFUN: fieldVal = {14'd0, bus.ARF_FunSel};
            F_RFREG:  fieldVal = {12'd0, bus.RF_RegSel};
            F_RFFUN:  fieldVal = {14'd0, bus.RF_FunSel};
            F_ALU:    fieldVal = {12'd0, bus.ALU_FunSel};
            F_OUTA:   fieldVal = {14'd0, bus.RF_OutASel};
            F_OUTB:   fieldVal = {14'd0, bus.RF_OutBSel};
            F_MUXA:   fieldVal = {14'd0, bus.MuxASel};
            F_MUXB:   fieldVal = {14'd0, bus.MuxBSel};
            default:  fieldVal = 16'hFFFF;
        endcase
    endfunction

    // Monitor: compare every expectation queued for the current cycle.
    initial begin
        exp_t        item;
        logic [15:0] actual;
        checks = 0;
        passed = 0;
        forever begin
            @(negedge Clock);
            while ((scoreQ.size() > 0) && (scoreQ[0].cyc <= cyc)) begin
                item   = scoreQ.pop_front();
                actual = fieldVal(item.field);
                checks++;
                if (item.cyc != cyc)
                    $display("FAIL %s: stale entry for cycle %0d at cycle %0d", item.name, item.cyc, cyc);
                else if (actual !== item.val)
                    $display("FAIL %s: cycle %0d got 0x%0h expected 0x%0h", item.name, cyc, actual, item.val);
                else
                    passed++;
            end
        end
    end

    task automatic pushExp(input int f, input logic [15:0] v, input string nm);
        exp_t e;
        e.cyc = cyc; e.field = f; e.val = v; e.name = nm;
        scoreQ.push_back(e);
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic resetChecks(input string tag);
        pushExp(F_ARFREG, 16'h0000, {tag, "_arf_regsel"});
        pushExp(F_ARFFUN, 16'h0003, {tag, "_arf_funsel"});
        pushExp(F_RFREG,  16'h0000, {tag, "_rf_regsel"});
        pushExp(F_RFFUN,  16'h0003, {tag, "_rf_funsel"});
        pushExp(F_IREN,   16'h0000, {tag, "_ir_en"});
    endtask

    // Pushes T0 and T1 checks and leaves the bench in the T2 cycle.
    task automatic fetch(input string tag);
        pushExp(F_SC,     16'h0000, {tag, "_t0_sc"});
        pushExp(F_IRLH,   16'h0000, {tag, "_t0_lh"});
        pushExp(F_IREN,   16'h0001, {tag, "_t0_iren"});
        pushExp(F_MEMCS,  16'h0000, {tag, "_t0_cs"});
        pushExp(F_ARFREG, 16'h0003, {tag, "_t0_pcsel"});
        pushExp(F_ARFFUN, 16'h0001, {tag, "_t0_pcinc"});
        tick();
        pushExp(F_SC,     16'h0001, {tag, "_t1_sc"});
        pushExp(F_IRLH,   16'h0001, {tag, "_t1_lh"});
        pushExp(F_IREN,   16'h0001, {tag, "_t1_iren"});
        pushExp(F_ARFREG, 16'h0003, {tag, "_t1_pcsel"});
        tick();
        pushExp(F_SC,     16'h0002, {tag, "_t2_sc"});
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        {mem[8'h00], mem[8'h01]} = {8'h05, 8'h52};  // LDI R1,0x05
        {mem[8'h02], mem[8'h03]} = {8'h40, 8'h31};  // ADD R1,R2,R2
        {mem[8'h04], mem[8'h05]} = {8'h00, 8'h81};  // INC R1,R2
        {mem[8'h06], mem[8'h07]} = {8'h00, 8'h91};  // DEC R1,R2
        {mem[8'h08], mem[8'h09]} = {8'h20, 8'h70};  // BNE 0x20 (taken)
        {mem[8'h20], mem[8'h21]} = {8'h20, 8'h70};  // BNE 0x20 (not taken)
        {mem[8'h22], mem[8'h23]} = {8'h00, 8'hB0};  // NOP
        {mem[8'h24], mem[8'h25]} = {8'h00, 8'hF0};  // HALT
        irModel = 16'h0000;
        pcModel = 8'h00;
        flag    = 4'b0000;
        Reset   = 1'b1;

        tick();
        resetChecks("rst1");
        tick();
        resetChecks("rst2");
        tick();
        Reset = 1'b0;

        fetch("ldi");
        pushExp(F_MUXA,  16'h0002, "ldi_muxa");
        pushExp(F_RFREG, 16'h0007, "ldi_rfreg");
        pushExp(F_RFFUN, 16'h0002, "ldi_rffun");
        tick();

        fetch("add");
        pushExp(F_ALU,   16'h0004, "add_alu");
        pushExp(F_OUTA,  16'h0001, "add_outa");
        pushExp(F_OUTB,  16'h0001, "add_outb");
        pushExp(F_RFREG, 16'h0007, "add_rfreg");
        pushExp(F_RFFUN, 16'h0002, "add_rffun");
        pushExp(F_MUXA,  16'h0000, "add_muxa");
        tick();

        fetch("inc");
        pushExp(F_ALU,   16'h0000, "inc_t2_alu");
        pushExp(F_OUTA,  16'h0001, "inc_t2_outa");
        pushExp(F_RFFUN, 16'h0002, "inc_t2_rffun");
        pushExp(F_RFREG, 16'h0007, "inc_t2_rfreg");
        tick();
        pushExp(F_SC,    16'h0003, "inc_t3_sc");
        pushExp(F_RFFUN, 16'h0001, "inc_t3_rffun");
        pushExp(F_RFREG, 16'h0007, "inc_t3_rfreg");
        tick();

        fetch("dec");
        pushExp(F_RFFUN, 16'h0002, "dec_t2_rffun");
        tick();
        pushExp(F_SC,    16'h0003, "dec_t3_sc");
        pushExp(F_RFFUN, 16'h0000, "dec_t3_rffun");
        pushExp(F_RFREG, 16'h0007, "dec_t3_rfreg");
        tick();

        flag = 4'b0000;
        fetch("bne_z0");
        pushExp(F_MUXB,   16'h0002, "bne_z0_muxb");
        pushExp(F_ARFFUN, 16'h0002, "bne_z0_arffun");
        pushExp(F_ARFREG, 16'h0003, "bne_z0_arfreg");
        tick();

        flag = 4'b1000;
        fetch("bne_z1");
        pushExp(F_ARFREG, 16'h0007, "bne_z1_arfreg");
        pushExp(F_ARFFUN, 16'h0000, "bne_z1_arffun");
        pushExp(F_MUXB,   16'h0000, "bne_z1_muxb");
        tick();

        flag = 4'b0000;
        fetch("nop");
        pushExp(F_RFREG,  16'h000F, "nop_rfreg");
        pushExp(F_ARFREG, 16'h0007, "nop_arfreg");
        pushExp(F_MEMCS,  16'h0001, "nop_cs");
        tick();

        fetch("halt");
        pushExp(F_HALT, 16'h0000, "halt_t2_halted");
        pushExp(F_ARFREG, 16'h0007, "halt_t2_arfreg");
        tick();
        for (int i = 0; i < 10; i++) begin
            pushExp(F_SC,     16'h0002, "halt_sc");
            pushExp(F_HALT,   16'h0001, "halt_halted");
            pushExp(F_IREN,   16'h0000, "halt_iren");
            pushExp(F_ARFREG, 16'h0007, "halt_arfreg");
            tick();
        end

        Reset = 1'b1;
        resetChecks("halt_rst");
        tick();
        Reset = 1'b0;
        pushExp(F_SC,   16'h0000, "post_halt_sc");
        pushExp(F_HALT, 16'h0000, "post_halt_halted");
        pushExp(F_IREN, 16'h0001, "post_halt_iren");
        tick();

        Reset = 1'b1;
        resetChecks("mid_rst");
        tick();
        Reset = 1'b0;
        fetch("refetch");
        pushExp(F_MUXA,  16'h0002, "refetch_ldi_muxa");
        pushExp(F_RFREG, 16'h0007, "refetch_ldi_rfreg");
        tick();
        pushExp(F_SC, 16'h0000, "refetch_next_sc");
        tick();
        tick();

        checks++;
        if (scoreQ.size() != 0)
            $display("FAIL drain: %0d entries left, required 0", scoreQ.size());
        else
            passed++;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
